// File: rtl/control_unit.sv
// control_unit: Moore sequencer driving the datapath control lines.
// Fetches an instruction (T0-T2), decodes ir[31:27] and steps through the
// register-transfer sequence of that instruction class (E3-E7). Stalls on
// mem_ready during memory accesses and halts on the halt opcode or on stop.
// Build option: CTRL_ILLEGAL_TRAP_EN makes illegal opcodes set the sticky
// illegal flag and halt; otherwise they behave as nop.
module control_unit #(
    parameter int T_WAIT_MAX = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        MDRout,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        PCin,
    output logic        incPC,
    output logic        Yin,
    output logic        Zin,
    output logic        HIin,
    output logic        LOin,
    output logic        Rin,
    output logic        R15jal,
    output logic        CONN_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        read,
    output logic        write,
    output logic [4:0]  opcode,
    output logic        run,
    output logic        illegal,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_E3   = 4'd3,
        S_E4   = 4'd4,
        S_E5   = 4'd5,
        S_E6   = 4'd6,
        S_E7   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        C_ALU, C_IMM, C_MULDIV, C_LD, C_ST, C_BR, C_JAL, C_NOP, C_HLT, C_ILL
    } iclass_t;

    state_t     cur_state;
    state_t     nxt_state;
    state_t     boundary;
    iclass_t    iclass;
    logic [4:0] op;
    logic       unused_bits;

    assign op          = ir[31:27];
    assign state       = cur_state;
    // Only the opcode field steers sequencing; the wait limit is reserved at 0.
    assign unused_bits = ^{ir[26:0], (T_WAIT_MAX != 0)};

    function automatic iclass_t decode_class(input logic [4:0] o);
        if (o <= 5'h0B)      return C_ALU;
        else if (o <= 5'h0E) return C_IMM;
        else if (o <= 5'h10) return C_MULDIV;
        case (o)
            5'h11:   return C_LD;
            5'h12:   return C_ST;
            5'h13:   return C_BR;
            5'h14:   return C_JAL;
            5'h15:   return C_NOP;
            5'h16:   return C_HLT;
            default: return C_ILL;
        endcase
    endfunction

    assign iclass = decode_class(op);

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!reset) cur_state <= S_T0;
        else        cur_state <= nxt_state;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky illegal-opcode flag, set when an illegal opcode is decoded in T2.
    always_ff @(posedge clock) begin
        if (!reset)                                  illegal_q <= 1'b0;
        else if (cur_state == S_T2 && iclass == C_ILL) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Next-state logic: fetch, per-class execute steps, memory waits, stop.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        nxt_state = cur_state;
        boundary  = stop ? S_HALT : S_T0;
        case (cur_state)
            S_T0: nxt_state = S_T1;
            S_T1: nxt_state = mem_ready ? S_T2 : S_T1;
            S_T2: begin
                case (iclass)
                    C_NOP:   nxt_state = boundary;
                    C_HLT:   nxt_state = S_HALT;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    C_ILL:   nxt_state = S_HALT;
`else
                    C_ILL:   nxt_state = boundary;
`endif
                    default: nxt_state = S_E3;
                endcase
            end
            S_E3: nxt_state = S_E4;
            S_E4: nxt_state = (iclass == C_JAL) ? boundary : S_E5;
            S_E5: nxt_state = (iclass == C_ALU || iclass == C_IMM) ? boundary : S_E6;
            S_E6: begin
                case (iclass)
                    C_LD:    nxt_state = mem_ready ? S_E7 : S_E6;
                    C_ST:    nxt_state = S_E7;
                    default: nxt_state = boundary;
                endcase
            end
            S_E7: begin
                if (iclass == C_ST && !mem_ready) nxt_state = S_E7;
                else                              nxt_state = boundary;
            end
            S_HALT:  nxt_state = S_HALT;
            default: nxt_state = S_T0;
        endcase
    end

    // Moore output decode from current state and instruction class.
    always_comb begin
        PCout = 1'b0; MDRout = 1'b0; ZLowOut = 1'b0; ZHighOut = 1'b0;
        Rout  = 1'b0; BAout  = 1'b0; Cout    = 1'b0;
        MARin = 1'b0; MDRin  = 1'b0; IRin    = 1'b0; PCin  = 1'b0;
        incPC = 1'b0; Yin    = 1'b0; Zin     = 1'b0; HIin  = 1'b0;
        LOin  = 1'b0; Rin    = 1'b0; R15jal  = 1'b0; CONN_in = 1'b0;
        Gra   = 1'b0; Grb    = 1'b0; Grc     = 1'b0;
        read  = 1'b0; write  = 1'b0;
        opcode = 5'h00;
        run    = (cur_state != S_HALT);
        case (cur_state)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; incPC = 1'b1; end
            S_T1: begin read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_E3: begin
                case (iclass)
                    C_ALU, C_IMM:  begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_MULDIV:      begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    C_LD, C_ST:    begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    C_BR:          begin Gra = 1'b1; Rout = 1'b1; CONN_in = 1'b1; end
                    C_JAL:         begin PCout = 1'b1; R15jal = 1'b1; end
                    default: ;
                endcase
            end
            S_E4: begin
                case (iclass)
                    C_ALU:    begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                    C_IMM: begin
                        Cout = 1'b1;
                        Zin  = 1'b1;
                        case (op)
                            5'h0D:   opcode = 5'h02;
                            5'h0E:   opcode = 5'h03;
                            default: opcode = 5'h00;
                        endcase
                    end
                    C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; opcode = op; end
                    C_LD, C_ST: begin Cout = 1'b1; Zin = 1'b1; end
                    C_BR:     begin PCout = 1'b1; Yin = 1'b1; end
                    C_JAL:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    default: ;
                endcase
            end
            S_E5: begin
                case (iclass)
                    C_ALU, C_IMM: begin ZLowOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_MULDIV:     begin ZLowOut = 1'b1; LOin = 1'b1; end
                    C_LD, C_ST:   begin ZLowOut = 1'b1; MARin = 1'b1; end
                    C_BR:         begin Cout = 1'b1; Zin = 1'b1; end
                    default: ;
                endcase
            end
            S_E6: begin
                case (iclass)
                    C_MULDIV: begin ZHighOut = 1'b1; HIin = 1'b1; end
                    C_LD:     begin read = 1'b1; MDRin = 1'b1; end
                    C_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    C_BR:     begin ZLowOut = con_ff; PCin = con_ff; end
                    default: ;
                endcase
            end
            S_E7: begin
                case (iclass)
                    C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    C_ST:    write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed, cycle-by-cycle checks of the control_unit
// state sequence and control outputs, with hand-computed expectations.
module tb_control_unit;

    logic        clock = 1'b0;
    logic        reset, stop, con_ff, mem_ready;
    logic [31:0] ir;
    logic PCout, MDRout, ZLowOut, ZHighOut, Rout, BAout, Cout;
    logic MARin, MDRin, IRin, PCin, incPC, Yin, Zin, HIin, LOin, Rin, R15jal, CONN_in;
    logic Gra, Grb, Grc, read, write, run, illegal;
    logic [4:0] opcode;
    logic [3:0] state;
    logic [23:0] ctl;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [3:0] T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, E3 = 4'd3, E4 = 4'd4,
                           E5 = 4'd5, E6 = 4'd6, E7 = 4'd7, HALT = 4'd8;

    localparam logic [23:0] PCOUT  = 24'h800000, MDROUT = 24'h400000, ZLO   = 24'h200000,
                            ZHI    = 24'h100000, ROUT   = 24'h080000, BAOUT = 24'h040000,
                            COUT   = 24'h020000, MARIN  = 24'h010000, MDRIN = 24'h008000,
                            IRIN   = 24'h004000, PCIN   = 24'h002000, INCPC = 24'h001000,
                            YIN    = 24'h000800, ZIN    = 24'h000400, HIIN  = 24'h000200,
                            LOIN   = 24'h000100, RIN    = 24'h000080, R15J  = 24'h000040,
                            CONNIN = 24'h000020, GRA    = 24'h000010, GRB   = 24'h000008,
                            GRC    = 24'h000004, RD     = 24'h000002, WR    = 24'h000001;

    control_unit dut (
        .clock(clock), .reset(reset), .stop(stop), .ir(ir), .con_ff(con_ff),
        .mem_ready(mem_ready),
        .PCout(PCout), .MDRout(MDRout), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .incPC(incPC),
        .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin), .Rin(Rin), .R15jal(R15jal),
        .CONN_in(CONN_in), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .read(read), .write(write), .opcode(opcode), .run(run),
        .illegal(illegal), .state(state)
    );

    assign ctl = {PCout, MDRout, ZLowOut, ZHighOut, Rout, BAout, Cout, MARin, MDRin,
                  IRin, PCin, incPC, Yin, Zin, HIin, LOin, Rin, R15jal, CONN_in,
                  Gra, Grb, Grc, read, write};

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [3:0] st, input logic [23:0] c,
                       input logic [4:0] opc);
        check({tag, ".state"},  32'(state),  32'(st));
        check({tag, ".ctl"},    32'(ctl),    32'(c));
        check({tag, ".opcode"}, 32'(opcode), 32'(opc));
        check({tag, ".run"},    32'(run),    32'(st != HALT));
    endtask

    // Checks T0, T1, T2 of a fetch with mem_ready high; ends one cycle after T2.
    task automatic fetch(input string tag, input logic [4:0] op);
        ir = {op, 27'h2A5_1C3};
        cyc({tag, ".T0"}, T0, PCOUT | MARIN | INCPC, 5'h00);
        step();
        cyc({tag, ".T1"}, T1, RD | MDRIN, 5'h00);
        step();
        cyc({tag, ".T2"}, T2, MDROUT | IRIN, 5'h00);
        step();
    endtask

    initial begin
        reset = 1'b0; stop = 1'b0; con_ff = 1'b0; mem_ready = 1'b1; ir = 32'h0;
        step(); step();
        cyc("reset_held", T0, PCOUT | MARIN | INCPC, 5'h00);
        check("reset_illegal", 32'(illegal), 32'h0);
        reset = 1'b1;

        // add: 6 cycles
        fetch("add", 5'h00);
        cyc("add.E3", E3, GRB | ROUT | YIN, 5'h00);       step();
        cyc("add.E4", E4, GRC | ROUT | ZIN, 5'h00);       step();
        cyc("add.E5", E5, ZLO | GRA | RIN, 5'h00);        step();

        // sub (0x03) routes the opcode field straight through in E4
        fetch("sub", 5'h03);
        cyc("sub.E3", E3, GRB | ROUT | YIN, 5'h00);       step();
        cyc("sub.E4", E4, GRC | ROUT | ZIN, 5'h03);       step();
        cyc("sub.E5", E5, ZLO | GRA | RIN, 5'h00);        step();

        // andi maps to ALU op 0x02
        fetch("andi", 5'h0D);
        cyc("andi.E3", E3, GRB | ROUT | YIN, 5'h00);      step();
        cyc("andi.E4", E4, COUT | ZIN, 5'h02);            step();
        cyc("andi.E5", E5, ZLO | GRA | RIN, 5'h00);       step();

        // ld with three mem_ready-low cycles in E6: 11 cycles total
        fetch("ld", 5'h11);
        cyc("ld.E3", E3, GRB | BAOUT | YIN, 5'h00);       step();
        cyc("ld.E4", E4, COUT | ZIN, 5'h00);              step();
        cyc("ld.E5", E5, ZLO | MARIN, 5'h00);             step();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc($sformatf("ld.E6_%0d", i), E6, RD | MDRIN, 5'h00);
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        cyc("ld.E7", E7, MDROUT | GRA | RIN, 5'h00);      step();

        // br not taken, then taken
        con_ff = 1'b0;
        fetch("br0", 5'h13);
        cyc("br0.E3", E3, GRA | ROUT | CONNIN, 5'h00);    step();
        cyc("br0.E4", E4, PCOUT | YIN, 5'h00);            step();
        cyc("br0.E5", E5, COUT | ZIN, 5'h00);             step();
        cyc("br0.E6", E6, 24'h0, 5'h00);                  step();
        con_ff = 1'b1;
        fetch("br1", 5'h13);
        cyc("br1.E3", E3, GRA | ROUT | CONNIN, 5'h00);    step();
        cyc("br1.E4", E4, PCOUT | YIN, 5'h00);            step();
        cyc("br1.E5", E5, COUT | ZIN, 5'h00);             step();
        cyc("br1.E6", E6, ZLO | PCIN, 5'h00);             step();
        con_ff = 1'b0;

        // jal: 5 cycles
        fetch("jal", 5'h14);
        cyc("jal.E3", E3, PCOUT | R15J, 5'h00);           step();
        cyc("jal.E4", E4, GRA | ROUT | PCIN, 5'h00);      step();

        // nop: 3 cycles, next fetch starts right after T2
        fetch("nop", 5'h15);

        // st with one wait cycle in E7
        fetch("st", 5'h12);
        cyc("st.E3", E3, GRB | BAOUT | YIN, 5'h00);       step();
        cyc("st.E4", E4, COUT | ZIN, 5'h00);              step();
        cyc("st.E5", E5, ZLO | MARIN, 5'h00);             step();
        cyc("st.E6", E6, GRA | ROUT | MDRIN, 5'h00);      step();
        mem_ready = 1'b0;
        cyc("st.E7_0", E7, WR, 5'h00);                    step();
        cyc("st.E7_1", E7, WR, 5'h00);
        mem_ready = 1'b1;                                  step();

        // st abandoned by reset in E6 while mem_ready is low
        fetch("st_rst", 5'h12);
        cyc("st_rst.E3", E3, GRB | BAOUT | YIN, 5'h00);   step();
        cyc("st_rst.E4", E4, COUT | ZIN, 5'h00);          step();
        cyc("st_rst.E5", E5, ZLO | MARIN, 5'h00);         step();
        mem_ready = 1'b0;
        reset     = 1'b0;
        cyc("st_rst.E6", E6, GRA | ROUT | MDRIN, 5'h00);  step();
        cyc("st_rst.T0", T0, PCOUT | MARIN | INCPC, 5'h00);
        reset = 1'b1; mem_ready = 1'b1;

        // illegal opcode 0x1A
        fetch("ill", 5'h1A);
`ifdef CTRL_ILLEGAL_TRAP_EN
        cyc("ill.halt", HALT, 24'h0, 5'h00);
        check("ill.flag", 32'(illegal), 32'h1);
        step();
        check("ill.sticky", 32'(illegal), 32'h1);
        reset = 1'b0;                                      step();
        reset = 1'b1;
        check("ill.cleared", 32'(illegal), 32'h0);
`else
        check("ill.flag", 32'(illegal), 32'h0);
`endif

        // mul with stop raised in E4: instruction completes, then HALT
        fetch("mul", 5'h0F);
        cyc("mul.E3", E3, GRA | ROUT | YIN, 5'h00);       step();
        cyc("mul.E4", E4, GRB | ROUT | ZIN, 5'h0F);
        stop = 1'b1;                                       step();
        cyc("mul.E5", E5, ZLO | LOIN, 5'h00);             step();
        cyc("mul.E6", E6, ZHI | HIIN, 5'h00);             step();
        cyc("mul.halt0", HALT, 24'h0, 5'h00);
        stop = 1'b0;                                       step();
        cyc("mul.halt1", HALT, 24'h0, 5'h00);
        reset = 1'b0;                                      step();
        reset = 1'b1;
        cyc("mul.restart", T0, PCOUT | MARIN | INCPC, 5'h00);

        // halt opcode
        fetch("hlt", 5'h16);
        cyc("hlt.halt0", HALT, 24'h0, 5'h00);             step();
        cyc("hlt.halt1", HALT, 24'h0, 5'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Microcoded-style Moore sequencer that drives the control inputs of `datapath`: it fetches an instruction, decodes `IR[31:27]`, then steps through the register-transfer sequence for that instruction class. It sits beside `datapath` in the CPU top level. It also stalls on a memory-ready handshake, and halts on a `halt` opcode or an external `stop`.

## Interface
- `T_WAIT_MAX`, default 0: reserved, must be 0. There is no memory timeout; the controller waits indefinitely for `mem_ready`.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `stop` in 1: request to halt at the next instruction boundary.
- `ir` in 32: IR contents from the datapath. Fields: `ir[31:27]` opcode.
- `con_ff` in 1: branch-condition flip-flop from the datapath.
- `mem_ready` in 1: memory has completed the current read or write.
- Bus-source outputs, 1 bit each: `PCout`, `MDRout`, `ZLowOut`, `ZHighOut`, `Rout`, `BAout`, `Cout`.
- Register-load outputs, 1 bit each: `MARin`, `MDRin`, `IRin`, `PCin`, `incPC`, `Yin`, `Zin`, `HIin`, `LOin`, `Rin`, `R15jal`, `CONN_in`.
- Register-select outputs, 1 bit each: `Gra`, `Grb`, `Grc`.
- `read` out 1: memory read strobe.
- `write` out 1: memory write strobe.
- `opcode` out 5: ALU operation.
- `run` out 1: high while the controller is not halted.
- `illegal` out 1: sticky flag for an illegal opcode.
- `state` out 4: current state encoding, for debug.

## Operation
- States: T0, T1, T2, E3, E4, E5, E6, E7, HALT. All outputs are decoded combinationally from `state` and `ir`.
- Outputs not listed for a state are 0 in that state. `opcode` is 0 unless listed.
- Fetch:
  - T0: `PCout`, `MARin`, `incPC`.
  - T1: `read`, `MDRin`. Holds in T1 until `mem_ready` = 1.
  - T2: `MDRout`, `IRin`.
- Opcode classes:
  - 0x00–0x0B, three-register ALU op:
    - E3: `Grb` `Rout` `Yin`.
    - E4: `Grc` `Rout` `Zin`, `opcode`=`ir[31:27]`.
    - E5: `ZLowOut` `Gra` `Rin`.
  - 0x0C/0x0D/0x0E, `addi`/`andi`/`ori`:
    - E3 as above.
    - E4: `Cout` `Zin`, `opcode`=0x00/0x02/0x03 respectively.
    - E5 as above.
  - 0x0F/0x10, `mul`/`div`:
    - E3: `Gra` `Rout` `Yin`.
    - E4: `Grb` `Rout` `Zin`, `opcode`=`ir[31:27]`.
    - E5: `ZLowOut` `LOin`.
    - E6: `ZHighOut` `HIin`.
  - 0x11, `ld`:
    - E3: `Grb` `BAout` `Yin`.
    - E4: `Cout` `Zin`, `opcode`=0x00.
    - E5: `ZLowOut` `MARin`.
    - E6: `read` `MDRin`. Holds until `mem_ready`.
    - E7: `MDRout` `Gra` `Rin`.
  - 0x12, `st`:
    - E3–E5 as `ld`.
    - E6: `Gra` `Rout` `MDRin`.
    - E7: `write`. Holds until `mem_ready`.
  - 0x13, `br`:
    - E3: `Gra` `Rout` `CONN_in`.
    - E4: `PCout` `Yin`.
    - E5: `Cout` `Zin`, `opcode`=0x00.
    - E6: `ZLowOut` `PCin` only if `con_ff`=1. If `con_ff`=0, E6 asserts nothing.
  - 0x14, `jal`:
    - E3: `PCout` `R15jal`.
    - E4: `Gra` `Rout` `PCin`.
  - 0x15, `nop`: T2 goes directly to T0.
  - 0x16, `halt`: T2 goes to HALT.
  - 0x17–0x1F: illegal. Handling is set by the Configuration section.
- The last execute step of every class returns to T0.
- HALT: all control outputs are 0 and `run`=0. HALT is left only by reset.
- `stop`:
  - Sampled only on the transition into T0.
  - If `stop`=1 at that edge, the next state is HALT instead of T0.
  - An instruction already in progress always completes.

## Timing
- While `reset`=0 at an edge, the next state is T0 and `illegal` is cleared.
- Any mid-instruction or mid-wait operation is abandoned by reset.
- After reset is released, T0 outputs and `run`=1 appear in the first cycle.
- Cycles per instruction, with `mem_ready` always 1:
  - ALU and immediate ops: 6.
  - `mul`/`div`, `br`: 7.
  - `ld`, `st`: 8.
  - `jal`: 5.
  - `nop`: 3.
- Each cycle with `mem_ready`=0 in T1, E6 (`ld`) or E7 (`st`) adds one cycle.
- During a wait, the strobes (`read`/`MDRin`, or `write`) stay asserted.
- `mem_ready` is ignored in every other state.
- `ir` must remain stable from the end of T2 until the next T0.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in T2 sets `illegal`=1, which stays set until reset.
  - The next state is HALT.
- `CTRL_ILLEGAL_TRAP_EN` not defined:
  - An illegal opcode is executed as `nop`.
  - `illegal` is tied to 0.

## Test plan
- Reset released, `ir`=`add` (0x00), `mem_ready`=1 -> `state` sequence T0,T1,T2,E3,E4,E5,T0. E4 shows `opcode`=0x00 with `Zin`=1. E5 shows `Rin`=1 and `Gra`=1.
- `ld` with `mem_ready` low for 3 cycles in E6 -> `read`=`MDRin`=1 held for 4 cycles, then E7 with `MDRout`=`Rin`=1. Total 11 cycles.
- `br` twice, with `con_ff`=0 and then `con_ff`=1 -> E6 `PCin`=0 in the first case and `PCin`=1 in the second. Both return to T0 after 7 cycles.
- `stop` pulsed during E4 of `mul` -> E5 `LOin`=1 and E6 `HIin`=1 still occur, then HALT with `run`=0. `reset`=0 for one edge then returns to T0.
- Opcode 0x1A -> with `CTRL_ILLEGAL_TRAP_EN`: `illegal`=1 and HALT after T2. Without it: T0 after T2 and `illegal`=0.
- `reset` driven low in E6 of `st` while `mem_ready`=0 -> next cycle is T0 with `write`=0.
